dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
Upstream neighbour of DataMemory. Accepts load/store requests from N_CORES GPU cores and serialises them onto DataMemory's single port (wren, AR, din, Q), using round-robin arbitration. Returns read data and a one-cycle acknowledge to the granted core. One transaction is in flight at a time.

Parameters:
N_CORES, 4, number of requesting cores (≥2)
ADDR_W, 16, DataMemory address width
DATA_W, 16, DataMemory data width

Ports:
clk  in  1  system clock; all state updates on posedge
rst  in  1  reset (see Interface)
req  in  N_CORES  per-core request
we  in  N_CORES  per-core write enable (1=store, 0=load)
addr  in  N_CORES*ADDR_W  packed addresses; core k at [k*ADDR_W +: ADDR_W]
wdata  in  N_CORES*DATA_W  packed store data, same packing
ack  out  N_CORES  one-hot completion pulse
rdata  out  DATA_W  load result; valid while ack is set for a load
busy  out  1  high whenever state is not IDLE
mem_wren  out  1  to DataMemory wren
mem_addr  out  ADDR_W  to DataMemory AR
mem_din  out  DATA_W  to DataMemory din
mem_q  in  DATA_W  from DataMemory Q

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Clock port is clk, reset port is rst.
- DataMemory contract: address, wren and din are sampled at posedge. For a read, Q is valid during the cycle after the sampling edge.
- Reset values:
  - ack=0, rdata=0, mem_wren=0, mem_addr=0, mem_din=0, busy=0
  - state=IDLE
  - last_grant=N_CORES-1, so core 0 wins first.
- All mem_* outputs and ack/rdata are registered.
- FSM states: IDLE, ACCESS, CAPTURE, ACK.
  - IDLE: if |req, choose g = first requesting index scanning last_grant+1 upward, modulo N_CORES. Latch g, we[g], addr[g] and wdata[g]. Load mem_addr/mem_din, set mem_wren=we[g], go to ACCESS. If no request, stay in IDLE with mem_wren=0.
  - ACCESS: memory samples the bus at the end of this cycle. Next state is ACK if the transaction is a write, CAPTURE if it is a read. mem_wren is cleared on exit, so it is high for exactly one cycle.
  - CAPTURE: rdata <= mem_q; go to ACK.
  - ACK: ack[g]=1 for exactly one cycle; last_grant <= g; go to IDLE.
- Latency, with req sampled high in IDLE at edge t:
  - write: ack high during cycle t+2
  - read: ack high during cycle t+3
- Minimum request spacing: 3 cycles for writes, 4 for reads.
- req is sampled only in IDLE. Once latched, a transaction completes even if req drops.
- A requester must hold req, we, addr and wdata until ack is seen. In the cycle after ack it either deasserts req or presents a new request.
- rdata holds its last value until the next load capture. For a write, ack is asserted with rdata unchanged.
- Wrap-around: last_grant=N_CORES-1 scans from 0. Addresses pass through unmodified, with no bounds checks.
- Simultaneous requests: exactly one grant per transaction. No core waits more than N_CORES-1 transactions.
- Reset mid-operation: rst overrides all states at the next edge. mem_wren is forced to 0 and no ack is issued for the aborted transaction. A write whose ACCESS edge has already passed has completed in memory.

Decomposition:
- constants.sv holds:
  - DMEM_ADDR_W=16 and DMEM_DATA_W=16
  - the FSM state encoding (2-bit localparams IDLE/ACCESS/CAPTURE/ACK)
- One sub-module, rr_arbiter: purely combinational.
  - Inputs: req and last_grant.
  - Outputs: grant index and grant_valid.
  - Parameterised by N_CORES.

Test Plan:
- Single write: core 2 drives we=1, addr=0x0005, wdata=0xBEEF in IDLE at t. Required: mem_wren=1, mem_addr=0x0005, mem_din=0xBEEF during t+1 only; ack=4'b0100 at t+2.
- Single read: memory preloaded with mem[i]=i+1; core 1 reads 0x0003. Required: ack=4'b0010 at t+3 and rdata=0x0004; mem_wren stays 0.
- Contention: all four cores request reads from reset. Required: grants in order 0,1,2,3, then 0 again on re-request, with exactly one ack bit per transaction.
- Fairness: core 3 completes, then cores 0 and 3 both request. Required: core 0 is granted first (scan starts at 0 because last_grant=3).
- Write then readback: core 0 writes 0x1234 to 0x000F, then reads 0x000F. Required: rdata=0x1234.
- Reset mid-read: assert rst during CAPTURE. Required: next cycle state=IDLE, busy=0, ack=0, rdata=0, and no ack ever appears for that request.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared constants and FSM encoding for the DataMemory request arbiter.
package dmem_arbiter_pkg;

  localparam int DMEM_ADDR_W = 16;
  localparam int DMEM_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    ACK     = 2'd3
  } state_t;

  // Width of a core index; a single core still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester after last_grant, wrapping.
module rr_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int N_CORES = 4,
  parameter int IW      = idx_w(N_CORES)
) (
  input  logic [N_CORES-1:0] req,
  input  logic [IW-1:0]      last_grant,
  output logic [IW-1:0]      grant,
  output logic               grant_valid
);

  int idx;

  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    idx         = 0;
    // Scan last_grant+1 .. last_grant+N_CORES so the previous winner is checked last.
    for (int i = 1; i <= N_CORES; i++) begin
      idx = (int'(last_grant) + i) % N_CORES;
      if (!grant_valid && req[idx[IW-1:0]]) begin
        grant       = idx[IW-1:0];
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Serialises per-core load/store requests onto DataMemory's single port,
// one transaction in flight, round-robin between cores.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int N_CORES = 4,
  parameter int ADDR_W  = DMEM_ADDR_W,
  parameter int DATA_W  = DMEM_DATA_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_CORES-1:0]          req,
  input  logic [N_CORES-1:0]          we,
  input  logic [N_CORES*ADDR_W-1:0]   addr,
  input  logic [N_CORES*DATA_W-1:0]   wdata,
  output logic [N_CORES-1:0]          ack,
  output logic [DATA_W-1:0]           rdata,
  output logic                        busy,
  output logic                        mem_wren,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_din,
  input  logic [DATA_W-1:0]           mem_q
);

  localparam int GW = idx_w(N_CORES);

  state_t              state, state_nx;
  logic [GW-1:0]       last_grant, last_grant_nx;
  logic [GW-1:0]       gsel, gsel_nx;
  logic                we_lat, we_lat_nx;
  logic [GW-1:0]       arb_grant;
  logic                arb_valid;
  logic [N_CORES-1:0]  ack_nx;
  logic [DATA_W-1:0]   rdata_nx;
  logic                mem_wren_nx;
  logic [ADDR_W-1:0]   mem_addr_nx;
  logic [DATA_W-1:0]   mem_din_nx;

  rr_arbiter #(
    .N_CORES (N_CORES),
    .IW      (GW)
  ) u_arb (
    .req         (req),
    .last_grant  (last_grant),
    .grant       (arb_grant),
    .grant_valid (arb_valid)
  );

  assign busy = (state != IDLE);

  always_comb begin
    state_nx      = state;
    last_grant_nx = last_grant;
    gsel_nx       = gsel;
    we_lat_nx     = we_lat;
    ack_nx        = '0;
    rdata_nx      = rdata;
    mem_wren_nx   = 1'b0;
    mem_addr_nx   = mem_addr;
    mem_din_nx    = mem_din;
    unique case (state)
      IDLE: begin
        if (arb_valid) begin
          gsel_nx     = arb_grant;
          we_lat_nx   = we[arb_grant];
          mem_wren_nx = we[arb_grant];
          mem_addr_nx = addr[int'(arb_grant)*ADDR_W +: ADDR_W];
          mem_din_nx  = wdata[int'(arb_grant)*DATA_W +: DATA_W];
          state_nx    = ACCESS;
        end
      end
      ACCESS: begin
        // Memory samples the bus at the end of this cycle; a write is done then.
        if (we_lat) begin
          ack_nx[gsel] = 1'b1;
          state_nx     = ACK;
        end else begin
          state_nx     = CAPTURE;
        end
      end
      CAPTURE: begin
        rdata_nx     = mem_q;
        ack_nx[gsel] = 1'b1;
        state_nx     = ACK;
      end
      ACK: begin
        last_grant_nx = gsel;
        state_nx      = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GW'(N_CORES - 1);
      gsel       <= '0;
      we_lat     <= 1'b0;
      ack        <= '0;
      rdata      <= '0;
      mem_wren   <= 1'b0;
      mem_addr   <= '0;
      mem_din    <= '0;
    end else begin
      state      <= state_nx;
      last_grant <= last_grant_nx;
      gsel       <= gsel_nx;
      we_lat     <= we_lat_nx;
      ack        <= ack_nx;
      rdata      <= rdata_nx;
      mem_wren   <= mem_wren_nx;
      mem_addr   <= mem_addr_nx;
      mem_din    <= mem_din_nx;
    end
  end

endmodule
